// File: rtl/reg_scoreboard_hazard.sv
// reg_scoreboard_hazard
//   RAW hazard detector for the ID stage built on a per-register scoreboard.
//   Every architectural register has a small counter that holds the number of
//   writers in flight to it. The counter goes up when an instruction that writes
//   the register issues, and goes down when WB retires that write. Because only
//   counters are kept, the pipeline depth does not matter, and multi-cycle units
//   are handled as well. Register 0 is hardwired to zero and is never tracked.
// Ports
//   clk_i           clock
//   reset_i         synchronous, active-high reset
//   rd_addr_i       source register addresses; port i is at [i*AW +: AW]
//   rd_en_i         port i actually reads its register
//   issue_valid_i   ID holds an instruction that is ready to issue
//   issue_we_i      the issuing instruction writes a register
//   issue_waddr_i   destination register of the issuing instruction
//   issue_ready_o   the issue may fire this cycle
//   retire_valid_i  WB commits a register write this cycle
//   retire_waddr_i  register committed by WB
//   flush_i         discard all in-flight writers
//   hazard_o        port i has a pending RAW hazard
//   occur_o         OR of hazard_o
//   busy_vec_o      bit r is set when the counter of register r is nonzero
//   stall_cnt_o     saturating count of cycles with issue_valid_i & ~issue_ready_o
//   sb_err_o        sticky flag: a retire arrived for a register whose count is 0
module reg_scoreboard_hazard #(
  parameter int NREG          = 32,
  parameter int AW            = 5,
  parameter int NRD           = 2,
  parameter int CNT_W         = 2,
  parameter int RETIRE_BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  input  logic [NRD-1:0]    rd_en_i,
  input  logic              issue_valid_i,
  input  logic              issue_we_i,
  input  logic [AW-1:0]     issue_waddr_i,
  output logic              issue_ready_o,
  input  logic              retire_valid_i,
  input  logic [AW-1:0]     retire_waddr_i,
  input  logic              flush_i,
  output logic [NRD-1:0]    hazard_o,
  output logic              occur_o,
  output logic [NREG-1:0]   busy_vec_o,
  output logic [31:0]       stall_cnt_o,
  output logic              sb_err_o
);

  localparam int NADDR = 2 ** AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]  ret_hit, iss_hit, pend, busy, blk;
  logic [NADDR-1:0] pend_ext;
  logic             fire, waw_full;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             sb_err_q, sb_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi = gi + 1) begin : g_reg
      if (gi == 0) begin : g_zero
        // Register 0 is never tracked. Its counter stays 0.
        assign ret_hit[gi] = 1'b0;
        assign iss_hit[gi] = 1'b0;
        assign pend[gi]    = 1'b0;
        assign blk[gi]     = 1'b0;
        assign busy[gi]    = (cnt_q[gi] != '0);
        assign cnt_d[gi]   = '0;
      end else begin : g_track
        assign ret_hit[gi] = retire_valid_i && (retire_waddr_i == AW'(gi));
        assign iss_hit[gi] = fire && issue_we_i && (issue_waddr_i == AW'(gi));
        assign busy[gi]    = (cnt_q[gi] != '0);
        // With bypass enabled, a retire of the last writer frees the register in the same cycle.
        assign pend[gi]    = busy[gi] &&
                             !((RETIRE_BYPASS != 0) && (cnt_q[gi] == CNT_W'(1)) && ret_hit[gi]);
        // A full counter blocks another writer unless a retire frees a slot in the same cycle.
        assign blk[gi]     = (issue_waddr_i == AW'(gi)) && (cnt_q[gi] == CNT_MAX) && !ret_hit[gi];
        assign cnt_d[gi]   = flush_i                                  ? '0 :
                             (iss_hit[gi] && !ret_hit[gi])            ? cnt_q[gi] + CNT_W'(1) :
                             (ret_hit[gi] && !iss_hit[gi] && busy[gi]) ? cnt_q[gi] - CNT_W'(1) :
                                                                        cnt_q[gi];
      end
    end

    // Zero-extend so that any address value selects a defined bit.
    assign pend_ext = NADDR'(pend);

    for (gi = 0; gi < NRD; gi = gi + 1) begin : g_port
      assign hazard_o[gi] = rd_en_i[gi] && pend_ext[rd_addr_i[gi*AW +: AW]];
    end
  endgenerate

  assign occur_o       = |hazard_o;
  assign waw_full      = issue_we_i && |blk;
  assign issue_ready_o = !flush_i && !occur_o && !waw_full;
  assign fire          = issue_valid_i && issue_ready_o;
  assign busy_vec_o    = busy;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid_i && !issue_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // A retire to an idle register is an error unless an issue to the same register
    // arrives in the same cycle. Retires in a flush cycle are ignored.
    sb_err_d = sb_err_q || (!flush_i && |(ret_hit & ~iss_hit & ~busy));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign sb_err_o    = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard_hazard.sv
module tb_reg_scoreboard_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_en;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_waddr;
  logic        retire_valid;
  logic [4:0]  retire_waddr;
  logic        flush;
  logic        issue_ready;
  logic [1:0]  hazard;
  logic        occur;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;
  logic        sb_err;

  // This second instance has the retire bypass disabled.
  logic [9:0]  b_rd_addr;
  logic [1:0]  b_rd_en;
  logic        b_issue_valid, b_issue_we;
  logic [4:0]  b_issue_waddr;
  logic        b_retire_valid;
  logic [4:0]  b_retire_waddr;
  logic        b_issue_ready;
  logic [1:0]  b_hazard;
  logic        b_occur;
  logic [31:0] b_busy_vec;
  logic [31:0] b_stall_cnt;
  logic        b_sb_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_scoreboard_hazard #(.RETIRE_BYPASS(1)) dut (
    .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_en_i(rd_en),
    .issue_valid_i(issue_valid), .issue_we_i(issue_we), .issue_waddr_i(issue_waddr),
    .issue_ready_o(issue_ready), .retire_valid_i(retire_valid), .retire_waddr_i(retire_waddr),
    .flush_i(flush), .hazard_o(hazard), .occur_o(occur), .busy_vec_o(busy_vec),
    .stall_cnt_o(stall_cnt), .sb_err_o(sb_err)
  );

  reg_scoreboard_hazard #(.RETIRE_BYPASS(0)) dut_nb (
    .clk_i(clk), .reset_i(reset), .rd_addr_i(b_rd_addr), .rd_en_i(b_rd_en),
    .issue_valid_i(b_issue_valid), .issue_we_i(b_issue_we), .issue_waddr_i(b_issue_waddr),
    .issue_ready_o(b_issue_ready), .retire_valid_i(b_retire_valid), .retire_waddr_i(b_retire_waddr),
    .flush_i(1'b0), .hazard_o(b_hazard), .occur_o(b_occur), .busy_vec_o(b_busy_vec),
    .stall_cnt_o(b_stall_cnt), .sb_err_o(b_sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock edge and leave 1 ns of settling time after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; rd_en = '0; issue_valid = 0; issue_we = 0; issue_waddr = '0;
    retire_valid = 0; retire_waddr = '0; flush = 0;
    b_rd_addr = '0; b_rd_en = '0; b_issue_valid = 0; b_issue_we = 0; b_issue_waddr = '0;
    b_retire_valid = 0; b_retire_waddr = '0;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1; issue_we = 1; issue_waddr = a;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_busy",   busy_vec, 32'h0);
    check("rst_stall",  stall_cnt, 32'd0);
    check("rst_sberr",  {31'd0, sb_err}, 32'd0);
    check("rst_hazard", {30'd0, hazard}, 32'd0);
    check("rst_ready",  {31'd0, issue_ready}, 32'd1);

    // 1: issue to r5, then read r5 and stall until r5 retires
    issue(5'd5); #1;
    check("t1_ready_first", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_we = 0; issue_waddr = '0; rd_addr = 10'd5; rd_en = 2'b01; #1;
    check("t1_hazard", {30'd0, hazard}, 32'd1);
    check("t1_occur",  {31'd0, occur}, 32'd1);
    check("t1_ready",  {31'd0, issue_ready}, 32'd0);
    check("t1_busy",   busy_vec, 32'h0000_0020);
    tick();
    check("t1_stall1", stall_cnt, 32'd1);
    tick();
    check("t1_stall2", stall_cnt, 32'd2);
    retire_valid = 1; retire_waddr = 5'd5; #1;
    check("t1_hazard_byp", {30'd0, hazard}, 32'd0);
    check("t1_ready_byp",  {31'd0, issue_ready}, 32'd1);
    tick();
    idle(); #1;
    check("t1_busy_after", busy_vec, 32'h0);
    check("t1_stall_hold", stall_cnt, 32'd2);

    // 2: fill the counter of r7, then issue and retire r7 in the same cycle
    issue(5'd7);
    tick(); tick(); tick();
    check("t2_busy7", busy_vec, 32'h0000_0080);
    check("t2_full_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    check("t2_stall", stall_cnt, 32'd3);
    retire_valid = 1; retire_waddr = 5'd7; #1;
    check("t2_ready_ret", {31'd0, issue_ready}, 32'd1);
    tick();
    retire_valid = 0; #1;
    check("t2_still_full", {31'd0, issue_ready}, 32'd0);
    idle();
    retire_valid = 1; retire_waddr = 5'd7;
    tick(); tick(); tick();
    idle(); #1;
    check("t2_drained", busy_vec, 32'h0);
    check("t2_sberr",   {31'd0, sb_err}, 32'd0);
    check("t2_stall_end", stall_cnt, 32'd3);

    // 3: register 0 is never tracked
    issue(5'd0);
    tick();
    idle(); rd_addr = 10'd0; rd_en = 2'b11; #1;
    check("t3_hazard", {30'd0, hazard}, 32'd0);
    check("t3_busy",   busy_vec, 32'h0);
    retire_valid = 1; retire_waddr = 5'd0;
    tick();
    idle(); #1;
    check("t3_sberr", {31'd0, sb_err}, 32'd0);

    // 4: flush drops r3 and r9; issue and retire in the flush cycle are ignored
    issue(5'd3); tick();
    issue(5'd9); tick();
    idle(); #1;
    check("t4_busy", busy_vec, 32'h0000_0208);
    flush = 1; issue(5'd11); retire_valid = 1; retire_waddr = 5'd3; #1;
    check("t4_ready_flush", {31'd0, issue_ready}, 32'd0);
    tick();
    idle(); #1;
    check("t4_busy_flushed", busy_vec, 32'h0);
    check("t4_sberr", {31'd0, sb_err}, 32'd0);
    check("t4_stall", stall_cnt, 32'd4);

    // 5: retire an idle register sets the sticky error
    retire_valid = 1; retire_waddr = 5'd12;
    tick();
    idle(); #1;
    check("t5_sberr", {31'd0, sb_err}, 32'd1);
    check("t5_busy",  busy_vec, 32'h0);
    tick();
    check("t5_sberr_sticky", {31'd0, sb_err}, 32'd1);

    // reset in the middle of activity clears everything
    issue(5'd6); tick();
    check("mid_busy6", busy_vec, 32'h0000_0040);
    reset = 1; issue(5'd8);
    tick();
    reset = 0; idle(); #1;
    check("mid_busy",  busy_vec, 32'h0);
    check("mid_stall", stall_cnt, 32'd0);
    check("mid_sberr", {31'd0, sb_err}, 32'd0);

    // 6: without bypass, a retire clears the hazard one cycle later
    b_issue_valid = 1; b_issue_we = 1; b_issue_waddr = 5'd4;
    tick();
    idle();
    b_rd_addr = 10'd4; b_rd_en = 2'b01; b_retire_valid = 1; b_retire_waddr = 5'd4; #1;
    check("t6_hazard_same", {30'd0, b_hazard}, 32'd1);
    tick();
    b_retire_valid = 0; #1;
    check("t6_hazard_next", {30'd0, b_hazard}, 32'd0);
    check("t6_busy",        b_busy_vec, 32'h0);
    check("t6_sberr",       {31'd0, b_sb_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
